// File: rtl/system_sequencer.sv
// system_sequencer: job-level control FSM stepping the datapath through LOAD, COMPUTE and DRAIN.
// Moore outputs registered from the next state. A start sampled at edge N gives LOAD from N+1.
// Stalled LOAD/DRAIN handshakes are watched; TIMEOUT quiet cycles force ERROR until abort/reset.
module system_sequencer #(
  parameter int LOAD_BEATS     = 16,
  parameter int COMPUTE_CYCLES = 32,
  parameter int OUT_BEATS      = 16,
  parameter int TIMEOUT        = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       compute_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXV = max2(max2(LOAD_BEATS, COMPUTE_CYCLES), max2(OUT_BEATS, TIMEOUT));
  localparam int CW   = $clog2(MAXV) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LOAD    = 3'b001,
    S_COMPUTE = 3'b010,
    S_DRAIN   = 3'b011,
    S_DONE    = 3'b100,
    S_ERROR   = 3'b101
  } state_e;

  // Kept as a raw vector so the illegal codes 110/111 remain representable and recoverable.
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          in_ready_q, compute_en_q, out_valid_q, busy_q, done_q, error_q;

  // Next-state and counter update; abort outranks everything except reset.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (abort) begin
      state_d     = S_IDLE;
      beat_cnt_d  = '0;
      cyc_cnt_d   = '0;
      stall_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          beat_cnt_d  = '0;
          cyc_cnt_d   = '0;
          stall_cnt_d = '0;
          if (start) state_d = S_LOAD;
        end
        // in_ready is high throughout LOAD, so in_valid alone marks a beat.
        S_LOAD: begin
          if (in_valid) begin
            stall_cnt_d = '0;
            if (beat_cnt_q == CW'(LOAD_BEATS - 1)) begin
              state_d    = S_COMPUTE;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end else if (stall_cnt_q == CW'(TIMEOUT - 1)) begin
            state_d     = S_ERROR;
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
        S_COMPUTE: begin
          stall_cnt_d = '0;
          if (cyc_cnt_q == CW'(COMPUTE_CYCLES - 1)) begin
            state_d   = S_DRAIN;
            cyc_cnt_d = '0;
          end else begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
          end
        end
        // out_valid is high throughout DRAIN, so out_ready alone marks a beat.
        S_DRAIN: begin
          if (out_ready) begin
            stall_cnt_d = '0;
            if (beat_cnt_q == CW'(OUT_BEATS - 1)) begin
              state_d    = S_DONE;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end else if (stall_cnt_q == CW'(TIMEOUT - 1)) begin
            state_d     = S_ERROR;
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_ERROR: begin
          beat_cnt_d  = '0;
          cyc_cnt_d   = '0;
          stall_cnt_d = '0;
        end
        default: begin
          state_d     = S_ERROR;
          beat_cnt_d  = '0;
          cyc_cnt_d   = '0;
          stall_cnt_d = '0;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs decode the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      cyc_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      in_ready_q   <= 1'b0;
      compute_en_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      in_ready_q   <= (state_d == S_LOAD);
      compute_en_q <= (state_d == S_COMPUTE);
      out_valid_q  <= (state_d == S_DRAIN);
      busy_q       <= (state_d == S_LOAD) || (state_d == S_COMPUTE) || (state_d == S_DRAIN);
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERROR);
    end
  end

  assign in_ready   = in_ready_q;
  assign compute_en = compute_en_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign state      = state_q;

endmodule
